// File: rtl/addsub_chunked.sv
// rtl/addsub_chunked.sv - multi-cycle chunked adder/subtractor with handshakes and V,N,Z,C flags
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;   // effective B, already inverted for subtraction
  logic             sub_q;
  logic             signed_q;
  logic [KW-1:0]    k;
  logic             carry;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] next_result;
  logic             c0;
  logic [3:0]       next_flags;

  assign a_chunk = a_q[int'(k)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k)*CHUNK +: CHUNK];
  assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};

  // A subtract runs as a + ~b + 1, so a stored borrow enters as an inverted carry.
  assign c0 = op[0] ? (cin_en ? ~flags[3] : 1'b1) : (cin_en ? flags[3] : 1'b0);

  always_comb begin
    next_result = result;
    next_result[int'(k)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_comb begin
    next_flags    = 4'b0000;
    next_flags[3] = sub_q ? ~sum[CHUNK] : sum[CHUNK];
    next_flags[2] = (next_result == '0);
    next_flags[1] = signed_q & next_result[WIDTH-1];
    next_flags[0] = signed_q & (a_q[WIDTH-1] == b_q[WIDTH-1])
                             & (next_result[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      signed_q  <= 1'b0;
      k         <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= op[0] ? ~b : b;
            sub_q    <= op[0];
            signed_q <= op[1];
            carry    <= c0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result <= next_result;
          carry  <= sum[CHUNK];
          if (k == KLAST) begin
            flags     <= next_flags;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
// tb/tb_addsub_chunked.sv - randomized self-checking bench for addsub_chunked against an arithmetic model
module tb_addsub_chunked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  op = '0;
  logic        cin_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [3:0]  flags;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_result = '0;
  logic [3:0]  exp_flags = '0;
  logic [3:0]  prev_flags = '0;
  logic [15:0] dut_result;
  logic [3:0]  dut_flags;

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin_en(cin_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] act, input logic [31:0] req, input string name);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Plain integer arithmetic: flags are {C,Z,N,V}, returned above the 16-bit result.
  function automatic logic [19:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic [1:0] iop, input logic icin, input logic cf);
    int ua, ub, sa, sb, ci, u, s;
    logic [15:0] r;
    logic c, z, n, v;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ci = icin ? int'(cf) : 0;
    if (!iop[0]) begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      c = (u > 65535);
    end else begin
      u = ua - ub - ci;
      s = sa - sb - ci;
      c = (u < 0);
    end
    r = u[15:0];
    z = (r == 16'h0000);
    n = iop[1] & r[15];
    v = iop[1] & ((s > 32767) || (s < -32768));
    return {c, z, n, v, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk(result, exp_result, "result");
        chk(flags, exp_flags, "flags");
        chk(in_ready, 1'b0, "in_ready_in_done");
        prev_flags = exp_flags;
      end else begin
        chk(flags, prev_flags, "flags_held");
      end
    end
  end

  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                       input logic icin, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(in_ready, 1'b1, "in_ready_before_accept");
    {exp_flags, exp_result} = model(ia, ib, iop, icin, prev_flags[3]);
    a = ia; b = ib; op = iop; cin_en = icin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin_en = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 20);
    chk(n, 4, "latency");
    dut_result = result;
    dut_flags = flags;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk(out_valid, 1'b1, "out_valid_held");
      chk(result, dut_result, "result_stable");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(out_valid, 1'b0, "out_valid_after_ready");
    chk(in_ready, 1'b1, "in_ready_after_ready");
  endtask

  task automatic lit(input logic [15:0] rres, input logic [3:0] rfl, input string name);
    chk(exp_result, rres, {name, "_model_result"});
    chk(exp_flags, rfl, {name, "_model_flags"});
    chk(dut_result, rres, {name, "_result"});
    chk(dut_flags, rfl, {name, "_flags"});
  endtask

  initial begin
    #12;
    chk(in_ready, 1'b1, "reset_in_ready");
    chk(out_valid, 1'b0, "reset_out_valid");
    chk(result, 16'h0000, "reset_result");
    chk(flags, 4'b0000, "reset_flags");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 0); lit(16'h0000, 4'b1100, "add_carry");
    do_op(16'h7FFF, 16'h0001, 2'b10, 1'b0, 1); lit(16'h8000, 4'b0011, "sadd_ovf");
    do_op(16'h8000, 16'h0001, 2'b11, 1'b0, 0); lit(16'h7FFF, 4'b0001, "ssub_ovf");
    do_op(16'h0003, 16'h0005, 2'b01, 1'b0, 0); lit(16'hFFFE, 4'b1000, "usub_borrow");
    do_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 0);
    do_op(16'h0000, 16'h0000, 2'b00, 1'b1, 0); lit(16'h0001, 4'b0000, "adc_chain");
    do_op(16'h0000, 16'h0001, 2'b01, 1'b0, 0);
    do_op(16'h0005, 16'h0002, 2'b01, 1'b1, 0); lit(16'h0002, 4'b0000, "sbc_chain");
    do_op(16'h1234, 16'h1234, 2'b01, 1'b0, 5); lit(16'h0000, 4'b0100, "backpressure");

    // Reset during the second RUN cycle after a flag-setting op.
    do_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 0);
    a = 16'h1111; b = 16'h2222; op = 2'b00; cin_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    prev_flags = 4'b0000;
    #1;
    chk(out_valid, 1'b0, "midrun_reset_out_valid");
    chk(flags, 4'b0000, "midrun_reset_flags");
    chk(in_ready, 1'b1, "midrun_reset_in_ready");
    chk(result, 16'h0000, "midrun_reset_result");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(16'h1111, 16'h2222, 2'b00, 1'b0, 0); lit(16'h3333, 4'b0000, "after_reset");

    for (int i = 0; i < 200; i++) begin
      do_op(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    do_op(16'h8000, 16'h8000, 2'b10, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_chunked.md
Name: addsub_chunked

Overview:
- Parametrised, multi-cycle adder/subtractor; successor to the 4-bit combinational flag adder.
- Width is generalised to WIDTH bits, processed CHUNK bits per cycle by a ripple-chunk datapath.
- Adds a valid/ready handshake on both sides, a persistent flag register (V,N,Z,C), and carry-in chaining (ADC/SBC) for multi-word arithmetic.
- Sits between the operand/decode stage and the register write-back / status-register logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. NCHUNK = WIDTH/CHUNK, which must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  op[0]=1 subtract / 0 add; op[1]=1 signed / 0 unsigned.
- cin_en  in  1  1 = use stored C flag as carry-in (add) or borrow-in (sub).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference.
- flags  out  4  [0]=V, [1]=N, [2]=Z, [3]=C. Holds the last completed operation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; result=0; flags=4'b0000.
  - Chunk index and internal carry are cleared.
  - Takes effect immediately, including mid-RUN; any in-flight op is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1 at a clock edge:
    - Latch a, b, op, cin_en.
    - Initial carry c0:
      - add: cin_en ? flags[3] : 0
      - sub: cin_en ? ~flags[3] : 1
    - Go to RUN with chunk index 0.
  - RUN: in_ready=0. Each cycle computes chunk k as a[k] + (op[0] ? ~b[k] : b[k]) + carry.
    - Writes the chunk into result[k*CHUNK +: CHUNK] and registers the carry-out.
    - k=0..NCHUNK-1, least-significant chunk first.
    - After the last chunk, go to DONE.
  - DONE: out_valid=1; result and flags are stable. When out_ready=1, go to IDLE.
- Latency: in_valid accepted at edge T gives out_valid=1 after edge T+NCHUNK. With defaults, 4 cycles.
- Throughput: at most one op per NCHUNK+2 cycles. No overlap.
- Flags are updated on the RUN→DONE edge only and held otherwise, including through IDLE.
  - C: add = final carry-out. Sub = borrow = NOT final carry-out, so 1 when unsigned a < b (+borrow-in).
  - Z: result == 0, in all modes.
  - N: op[1] ? result[WIDTH-1] : 0.
  - V: op[1] ? (a[MSB]==b'[MSB] && result[MSB]!=a[MSB]) : 0, where b' is the effective (possibly inverted) B.
- result is internally updated chunk-wise during RUN but is only defined for the consumer when out_valid=1. It holds its value in DONE and IDLE.
- in_valid is ignored outside IDLE. Operands may change after acceptance without effect.
- out_ready is ignored outside DONE.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Test Plan:
- Unsigned add 0xFFFF+0x0001, op=00, cin_en=0 → result 0x0000, flags 4'b1100 (C,Z). out_valid rises exactly 4 cycles after acceptance.
- Signed add 0x7FFF+0x0001, op=10 → result 0x8000, flags 4'b0011 (N,V). Signed sub 0x8000−0x0001, op=11 → result 0x7FFF, flags 4'b0001 (V).
- Unsigned sub 0x0003−0x0005, op=01 → result 0xFFFE, flags 4'b1000 (borrow C=1; N=V=0 because unsigned).
- Chaining:
  - 0xFFFF+0x0001 (C=1), then 0x0000+0x0000 with cin_en=1 → result 0x0001, flags 4'b0000.
  - 0x0000−0x0001 (C=1), then 0x0005−0x0002 with cin_en=1 → result 0x0002.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, result and flags remain constant and in_ready=0. in_valid pulses with other operands are ignored. Acceptance resumes the cycle after out_ready=1.
- Reset: assert rst_n=0 in the 2nd RUN cycle → outputs go to reset values immediately (out_valid=0, flags=0, in_ready=1). A new op after release completes normally with correct values.
